// File: rtl/sequenciador_jogadas_pkg.sv
// Shared types and constants for the move sequencer.
// State codes are visible on db_estado, so their values are fixed.
package sequenciador_jogadas_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        PREPARA    = 4'd1,
        ESPERA     = 4'd2,
        REGISTRA   = 4'd3,
        COMPARA    = 4'd4,
        PROXIMO    = 4'd5,
        FIM_ACERTO = 4'd6,
        FIM_ERRO   = 4'd7
    } estado_t;

    localparam int ACERTOS_W  = 5;
    localparam int ENDERECO_W = 4;

endpackage

// File: rtl/sequenciador_jogadas_contador.sv
// Synchronous up counter with clear and enable.
// Addresses the external sequence ROM.
module contador_163 #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         conta,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            q <= '0;
        end else if (conta) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sequenciador_jogadas.sv
// Walks the stored sequence, registers one move per position and
// decides hit/miss from the external comparator flags.
module sequenciador_jogadas
    import sequenciador_jogadas_pkg::*;
#(
    parameter int N_JOGADAS = 16,
    parameter int LARGURA   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 jogada_valida,
    input  logic [LARGURA-1:0]   jogada,
    output logic [3:0]           rom_endereco,
    input  logic [LARGURA-1:0]   rom_dado,
    output logic [LARGURA-1:0]   cmp_a,
    output logic [LARGURA-1:0]   cmp_b,
    input  logic                 cmp_igual,
    input  logic                 cmp_menor,
    input  logic                 cmp_maior,
    output logic                 pronto,
    output logic                 acertou,
    output logic                 errou,
    output logic                 dica_menor,
    output logic                 dica_maior,
    output logic [ACERTOS_W-1:0] acertos,
    output logic [3:0]           db_estado
);

    estado_t estado;
    estado_t estado_prox;

    logic limpa;
    logic conta;
    logic carrega_a;
    logic soma;
    logic carrega_dica;
    logic ultimo;

    contador_163 #(
        .W (ENDERECO_W)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .limpa (limpa),
        .conta (conta),
        .q     (rom_endereco)
    );

    assign ultimo = (rom_endereco == ENDERECO_W'(N_JOGADAS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        limpa        = 1'b0;
        conta        = 1'b0;
        carrega_a    = 1'b0;
        soma         = 1'b0;
        carrega_dica = 1'b0;
        case (estado)
            INICIAL: begin
                if (iniciar) estado_prox = PREPARA;
            end
            PREPARA: begin
                limpa       = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA: begin
                if (jogada_valida) estado_prox = REGISTRA;
            end
            REGISTRA: begin
                carrega_a   = 1'b1;
                estado_prox = COMPARA;
            end
            COMPARA: begin
                if (cmp_igual) begin
                    soma        = 1'b1;
                    estado_prox = ultimo ? FIM_ACERTO : PROXIMO;
                end else begin
                    carrega_dica = 1'b1;
                    estado_prox  = FIM_ERRO;
                end
            end
            PROXIMO: begin
                conta       = 1'b1;
                estado_prox = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO: begin
                if (iniciar) estado_prox = PREPARA;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            cmp_a      <= '0;
            acertos    <= '0;
            dica_menor <= 1'b0;
            dica_maior <= 1'b0;
        end else begin
            if (carrega_a) cmp_a <= jogada;
            if (soma) acertos <= acertos + ACERTOS_W'(1);
            if (carrega_dica) begin
                dica_menor <= cmp_menor;
                dica_maior <= cmp_maior;
            end
        end
    end

    assign cmp_b     = rom_dado;
    assign pronto    = (estado == FIM_ACERTO) || (estado == FIM_ERRO);
    assign acertou   = (estado == FIM_ACERTO);
    assign errou     = (estado == FIM_ERRO);
    assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_jogadas.sv
// Scoreboard bench: rounds are predicted from the game rules and
// checked by a monitor whenever the block reports a finished round.
module tb_sequenciador_jogadas;

    localparam int N = 4;

    typedef logic [3:0] vec_t [N];

    typedef struct packed {
        logic       acertou;
        logic       errou;
        logic [4:0] acertos;
        logic [3:0] endereco;
        logic       menor;
        logic       maior;
        logic [3:0] estado;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada_valida;
    logic [3:0] jogada;
    logic [3:0] rom_endereco;
    logic [3:0] rom_dado;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_igual;
    logic       cmp_menor;
    logic       cmp_maior;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       dica_menor;
    logic       dica_maior;
    logic [4:0] acertos;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    int   checks = 0;
    int   errors = 0;
    exp_t fila [$];
    logic pronto_ant = 1'b0;

    always #5 clk = ~clk;

    assign rom_dado  = rom[rom_endereco];
    assign cmp_igual = (cmp_a == cmp_b);
    assign cmp_menor = (cmp_a <  cmp_b);
    assign cmp_maior = (cmp_a >  cmp_b);

    sequenciador_jogadas #(
        .N_JOGADAS (N),
        .LARGURA   (4)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .jogada_valida (jogada_valida),
        .jogada        (jogada),
        .rom_endereco  (rom_endereco),
        .rom_dado      (rom_dado),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .cmp_igual     (cmp_igual),
        .cmp_menor     (cmp_menor),
        .cmp_maior     (cmp_maior),
        .pronto        (pronto),
        .acertou       (acertou),
        .errou         (errou),
        .dica_menor    (dica_menor),
        .dica_maior    (dica_maior),
        .acertos       (acertos),
        .db_estado     (db_estado)
    );

    task automatic check(input string nome, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nome, act, req);
        end
    endtask

    // Round outcome from the rules: first mismatching position decides.
    function automatic exp_t modelo(input vec_t r, input vec_t m);
        exp_t e;
        int   i;
        e = '0;
        i = 0;
        while (i < N && m[i] == r[i]) i++;
        if (i == N) begin
            e.acertou  = 1'b1;
            e.acertos  = 5'(N);
            e.endereco = 4'(N - 1);
            e.estado   = 4'd6;
        end else begin
            e.errou    = 1'b1;
            e.acertos  = 5'(i);
            e.endereco = 4'(i);
            e.menor    = (m[i] < r[i]);
            e.maior    = (m[i] > r[i]);
            e.estado   = 4'd7;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (pronto && !pronto_ant) begin
            if (fila.size() == 0) begin
                check("unexpected_end", 1, 0);
            end else begin
                exp_t e;
                e = fila.pop_front();
                check("acertou", int'(acertou), int'(e.acertou));
                check("errou", int'(errou), int'(e.errou));
                check("acertos", int'(acertos), int'(e.acertos));
                check("endereco", int'(rom_endereco), int'(e.endereco));
                check("dica_menor", int'(dica_menor), int'(e.menor));
                check("dica_maior", int'(dica_maior), int'(e.maior));
                check("db_estado", int'(db_estado), int'(e.estado));
            end
        end
        pronto_ant = pronto;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_estado(input logic [3:0] alvo);
        int n;
        n = 0;
        while (db_estado != alvo && n < 50) begin
            tick();
            n++;
        end
        if (db_estado != alvo) check("timeout_estado", int'(db_estado), int'(alvo));
    endtask

    task automatic inicia();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic joga(input logic [3:0] v);
        wait_estado(4'd2);
        jogada        = v;
        jogada_valida = 1'b1;
        tick();
        jogada_valida = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic rodada(input vec_t r, input vec_t m);
        for (int i = 0; i < N; i++) rom[i] = r[i];
        fila.push_back(modelo(r, m));
        inicia();
        for (int i = 0; i < N; i++) begin
            joga(m[i]);
            if (m[i] != r[i]) break;
        end
        begin
            int n;
            n = 0;
            while (!pronto && n < 20) begin
                tick();
                n++;
            end
            if (!pronto) check("timeout_pronto", 0, 1);
        end
        tick();
    endtask

    initial begin
        vec_t r;
        vec_t m;
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        reset         = 1'b1;
        iniciar       = 1'b0;
        jogada_valida = 1'b0;
        jogada        = '0;
        repeat (2) tick();
        reset = 1'b0;

        check("rst_estado", int'(db_estado), 0);
        check("rst_pronto", int'({pronto, acertou, errou}), 0);
        check("rst_dicas", int'({dica_menor, dica_maior}), 0);
        check("rst_acertos", int'(acertos), 0);
        check("rst_end", int'(rom_endereco), 0);
        check("rst_cmp_a", int'(cmp_a), 0);

        // strobe while idle must not start anything
        jogada_valida = 1'b1;
        repeat (3) tick();
        jogada_valida = 1'b0;
        check("idle_strobe", int'(db_estado), 0);

        // full success, with a strobe held across REGISTRA/COMPARA
        r = '{4'd3, 4'd7, 4'd0, 4'd15};
        for (int i = 0; i < N; i++) rom[i] = r[i];
        fila.push_back(modelo(r, r));
        inicia();
        wait_estado(4'd2);
        jogada        = 4'd3;
        jogada_valida = 1'b1;
        tick();
        check("st_registra", int'(db_estado), 3);
        tick();
        check("st_compara", int'(db_estado), 4);
        check("cmp_a_load", int'(cmp_a), 3);
        tick();
        jogada_valida = 1'b0;
        check("st_proximo", int'(db_estado), 5);
        tick();
        repeat (3) tick();
        check("drop_estado", int'(db_estado), 2);
        check("drop_acertos", int'(acertos), 1);
        check("drop_end", int'(rom_endereco), 1);
        joga(4'd7);
        joga(4'd0);
        joga(4'd15);
        wait_estado(4'd6);
        tick();

        // early mismatch, move above stored value
        m = '{4'd3, 4'd9, 4'd0, 4'd0};
        rodada(r, m);

        // restart from FIM_ERRO clears hints; move below ROM[0]
        r = '{4'd12, 4'd1, 4'd2, 4'd3};
        for (int i = 0; i < N; i++) rom[i] = r[i];
        m = '{4'd2, 4'd0, 4'd0, 4'd0};
        fila.push_back(modelo(r, m));
        inicia();
        wait_estado(4'd2);
        check("restart_dicas", int'({dica_menor, dica_maior}), 0);
        check("restart_acertos", int'(acertos), 0);
        joga(4'd2);
        wait_estado(4'd7);
        tick();

        rodada(r, r);

        // reset during COMPARA of position 2, with iniciar in the same cycle
        r = '{4'd5, 4'd6, 4'd8, 4'd9};
        for (int i = 0; i < N; i++) rom[i] = r[i];
        inicia();
        joga(r[0]);
        joga(r[1]);
        wait_estado(4'd2);
        jogada        = r[2];
        jogada_valida = 1'b1;
        tick();
        jogada_valida = 1'b0;
        tick();
        check("pre_rst_estado", int'(db_estado), 4);
        reset   = 1'b1;
        iniciar = 1'b1;
        tick();
        reset   = 1'b0;
        iniciar = 1'b0;
        check("mid_rst_estado", int'(db_estado), 0);
        check("mid_rst_acertos", int'(acertos), 0);
        check("mid_rst_end", int'(rom_endereco), 0);
        check("mid_rst_cmp_a", int'(cmp_a), 0);
        check("mid_rst_flags", int'({pronto, acertou, errou, dica_menor, dica_maior}), 0);
        tick();
        check("no_start", int'(db_estado), 0);

        // random rounds
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                r[i] = 4'($urandom_range(0, 15));
                m[i] = ($urandom_range(0, 3) != 0) ? r[i] : 4'($urandom_range(0, 15));
            end
            rodada(r, m);
        end

        repeat (5) tick();
        check("fila_vazia", fila.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
